// File: rtl/unidade_controle_sequencia_pkg.sv
// State codes and the control-strobe bundle shared by the sequence-game controller.
// No latency and no backpressure; this file holds types and constants only.
package unidade_controle_sequencia_pkg;

    localparam int ESTADO_BITS = 4;

    typedef enum logic [ESTADO_BITS-1:0] {
        INICIAL           = 4'h0,
        PREPARACAO        = 4'h1,
        NOVA_SEQUENCIA    = 4'h2,
        ESPERA_JOGADA     = 4'h3,
        REGISTRA          = 4'h4,
        COMPARACAO        = 4'h5,
        PROXIMA_JOGADA    = 4'h6,
        PROXIMA_SEQUENCIA = 4'h7,
        FIM_ACERTOU       = 4'hA,
        FIM_TIMEOUT       = 4'hD,
        FIM_ERROU         = 4'hE
    } estado_t;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_l;
        logic conta_l;
        logic zera_r;
        logic registra_r;
        logic zera_timer;
        logic conta_timer;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } ctrl_t;

    function automatic logic eh_fim(estado_t e);
        return (e == FIM_ACERTOU) || (e == FIM_TIMEOUT) || (e == FIM_ERROU);
    endfunction

endpackage

// File: rtl/unidade_controle_sequencia.sv
// Moore controller for the memory-sequence game; a play pulse reaches its decision 2 edges later.
// No backpressure: strobes are decoded from state only, and end states wait for iniciar.
module unidade_controle_sequencia
    import unidade_controle_sequencia_pkg::*;
#(
    parameter int ESTADO_W    = ESTADO_BITS,
    parameter bit USA_TIMEOUT = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogada_feita,
    input  logic                igual,
    input  logic                fim_sequencia,
    input  logic                ultima_sequencia,
    input  logic                fim_timer,
    output logic                zeraE,
    output logic                contaE,
    output logic                zeraL,
    output logic                contaL,
    output logic                zeraR,
    output logic                registraR,
    output logic                zera_timer,
    output logic                conta_timer,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t estado;
    estado_t proximo;
    ctrl_t   ctrl;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:           if (iniciar) proximo = PREPARACAO;
            PREPARACAO:        proximo = ESPERA_JOGADA;
            NOVA_SEQUENCIA:    proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A play arriving together with the timeout still counts.
                if (jogada_feita) begin
                    proximo = REGISTRA;
                end else if (fim_timer && USA_TIMEOUT) begin
                    proximo = FIM_TIMEOUT;
                end
            end
            REGISTRA:          proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    proximo = FIM_ERROU;
                end else if (!fim_sequencia) begin
                    proximo = PROXIMA_JOGADA;
                end else if (ultima_sequencia) begin
                    proximo = FIM_ACERTOU;
                end else begin
                    proximo = PROXIMA_SEQUENCIA;
                end
            end
            PROXIMA_JOGADA:    proximo = ESPERA_JOGADA;
            PROXIMA_SEQUENCIA: proximo = NOVA_SEQUENCIA;
            FIM_ACERTOU,
            FIM_TIMEOUT,
            FIM_ERROU:         if (iniciar) proximo = PREPARACAO;
            default:           proximo = INICIAL;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (estado)
            PREPARACAO: begin
                ctrl.zera_e     = 1'b1;
                ctrl.zera_l     = 1'b1;
                ctrl.zera_r     = 1'b1;
                ctrl.zera_timer = 1'b1;
            end
            NOVA_SEQUENCIA: begin
                ctrl.zera_e     = 1'b1;
                ctrl.zera_r     = 1'b1;
                ctrl.zera_timer = 1'b1;
            end
            ESPERA_JOGADA:     ctrl.conta_timer = 1'b1;
            REGISTRA:          ctrl.registra_r  = 1'b1;
            PROXIMA_JOGADA: begin
                // Each play gets a fresh timeout window.
                ctrl.conta_e    = 1'b1;
                ctrl.zera_timer = 1'b1;
            end
            PROXIMA_SEQUENCIA: ctrl.conta_l = 1'b1;
            FIM_ACERTOU:       ctrl.acertou = 1'b1;
            FIM_TIMEOUT:       ctrl.timeout = 1'b1;
            FIM_ERROU:         ctrl.errou   = 1'b1;
            default:           ctrl = '0;
        endcase
        ctrl.pronto = eh_fim(estado);
    end

    assign zeraE       = ctrl.zera_e;
    assign contaE      = ctrl.conta_e;
    assign zeraL       = ctrl.zera_l;
    assign contaL      = ctrl.conta_l;
    assign zeraR       = ctrl.zera_r;
    assign registraR   = ctrl.registra_r;
    assign zera_timer  = ctrl.zera_timer;
    assign conta_timer = ctrl.conta_timer;
    assign pronto      = ctrl.pronto;
    assign acertou     = ctrl.acertou;
    assign errou       = ctrl.errou;
    assign timeout     = ctrl.timeout;
    assign db_estado   = ESTADO_W'(estado);

endmodule

// File: tb/tb_unidade_controle_sequencia.sv
// Bench: behavioural datapath plus game-level scoreboard for the sequence controller.
module tb_unidade_controle_sequencia;

    typedef struct packed {
        logic [3:0] estado;
        int         ce;
        int         cl;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, iniciar, jogada_feita, igual, fim_sequencia, ultima_sequencia, fim_timer;
    logic zeraE, contaE, zeraL, contaL, zeraR, registraR, zera_timer, conta_timer;
    logic pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    logic iniciar_b, jogada_b, fim_timer_b;
    logic zeraE_b, contaE_b, zeraL_b, contaL_b, zeraR_b, registraR_b, zera_timer_b, conta_timer_b;
    logic pronto_b, acertou_b, errou_b, timeout_b;
    logic [3:0] db_estado_b;
    logic zero_b;

    unidade_controle_sequencia #(.ESTADO_W(4), .USA_TIMEOUT(1'b1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fim_sequencia(fim_sequencia), .ultima_sequencia(ultima_sequencia),
        .fim_timer(fim_timer), .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .zera_timer(zera_timer), .conta_timer(conta_timer),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    unidade_controle_sequencia #(.ESTADO_W(4), .USA_TIMEOUT(1'b0)) dut_sem_timeout (
        .clock(clock), .reset(reset), .iniciar(iniciar_b), .jogada_feita(jogada_b),
        .igual(zero_b), .fim_sequencia(zero_b), .ultima_sequencia(zero_b),
        .fim_timer(fim_timer_b), .zeraE(zeraE_b), .contaE(contaE_b), .zeraL(zeraL_b),
        .contaL(contaL_b), .zeraR(zeraR_b), .registraR(registraR_b), .zera_timer(zera_timer_b),
        .conta_timer(conta_timer_b), .pronto(pronto_b), .acertou(acertou_b), .errou(errou_b),
        .timeout(timeout_b), .db_estado(db_estado_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Behavioural datapath: address/limit counters, play register, sequence ROM.
    logic [3:0] rom [0:7];
    logic [2:0] endereco = '0;
    logic [2:0] limite = '0;
    logic [2:0] n_last = '0;
    logic [3:0] jogada_reg = '0;
    logic [3:0] play_val = '0;

    always @(posedge clock) begin
        if (zeraE) endereco <= '0;
        else if (contaE) endereco <= endereco + 3'd1;
        if (zeraL) limite <= '0;
        else if (contaL) limite <= limite + 3'd1;
        if (zeraR) jogada_reg <= '0;
        else if (registraR) jogada_reg <= play_val;
    end

    assign igual            = (jogada_reg == rom[endereco]);
    assign fim_sequencia    = (endereco == limite);
    assign ultima_sequencia = (limite == n_last);

    // Scoreboard monitor: one expected record per game, popped when the game ends.
    exp_t sb_q[$];
    logic pronto_q = 1'b0;
    int   cnt_e = 0;
    int   cnt_l = 0;

    function automatic logic [2:0] flags_de(input logic [3:0] e);
        case (e)
            4'hA:    return 3'b100;
            4'hE:    return 3'b010;
            4'hD:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (zeraL) begin
            cnt_e <= 0;
            cnt_l <= 0;
        end else begin
            if (contaE) cnt_e <= cnt_e + 1;
            if (contaL) cnt_l <= cnt_l + 1;
        end
        if (pronto && !pronto_q) begin
            if (sb_q.size() == 0) begin
                check("unexpected_end", 32'(db_estado), 32'hF);
            end else begin
                e = sb_q.pop_front();
                check("end_estado", 32'(db_estado), 32'(e.estado));
                check("end_flags", 32'({acertou, errou, timeout}), 32'(flags_de(e.estado)));
                check("end_contaE", cnt_e, e.ce);
                check("end_contaL", cnt_l, e.cl);
            end
        end
        pronto_q <= pronto;
    end

    task automatic wait_espera(output bit ok);
        int n = 0;
        @(negedge clock);
        while (!conta_timer && n < 40) begin
            @(negedge clock);
            n++;
        end
        ok = conta_timer;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_espera: conta_timer=0 after 40 cycles, expected 1");
        end
    endtask

    // kind 0: all rounds correct; 1: wrong play at (fk,fj); 2: timeout at (fk,fj)
    task automatic run_game(input int n, input int kind, input int fk, input int fj, output bit ok);
        exp_t e;
        bit   fim = 0;
        int   n_wait;
        logic [3:0] m;
        ok = 1;
        for (int i = 0; i < 8; i++) rom[i] = 4'($urandom_range(0, 15));
        n_last = 3'(n - 1);
        if (kind == 0) begin
            e.estado = 4'hA;
            e.ce = n * (n - 1) / 2;
            e.cl = n - 1;
        end else begin
            e.estado = (kind == 1) ? 4'hE : 4'hD;
            e.ce = fk * (fk - 1) / 2 + fj;
            e.cl = fk;
        end
        sb_q.push_back(e);
        @(posedge clock); #1 iniciar = 1'b1;
        @(posedge clock); #1 iniciar = 1'b0;
        @(negedge clock);
        check("start_state", 32'(db_estado), 32'h1);
        check("start_pronto", 32'(pronto), 32'h0);
        for (int k = 0; k < n && !fim; k++) begin
            for (int j = 0; j <= k && !fim; j++) begin
                wait_espera(ok);
                if (!ok) return;
                repeat ($urandom_range(0, 2)) @(negedge clock);
                @(posedge clock); #1;
                if (kind == 2 && k == fk && j == fj) begin
                    fim_timer = 1'b1;
                    @(posedge clock); #1 fim_timer = 1'b0;
                    fim = 1;
                end else begin
                    play_val = rom[3'(j)];
                    if (kind == 1 && k == fk && j == fj) begin
                        m = 4'($urandom_range(1, 15));
                        play_val = play_val ^ m;
                        fim = 1;
                    end
                    jogada_feita = 1'b1;
                    fim_timer = 1'($urandom_range(0, 1));
                    @(posedge clock); #1;
                    jogada_feita = 1'b0;
                    fim_timer = 1'b0;
                    @(negedge clock);
                    check("registra_state", 32'(db_estado), 32'h4);
                end
            end
        end
        n_wait = 0;
        @(negedge clock);
        while (!pronto && n_wait < 20) begin
            @(negedge clock);
            n_wait++;
        end
        if (!pronto) begin
            ok = 0;
            tests++;
            fails++;
            $display("FAIL wait_pronto: pronto=0 after 20 cycles, expected 1");
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n, kind, fk, fj;
        reset = 1'b1; iniciar = 1'b0; jogada_feita = 1'b0; fim_timer = 1'b0;
        iniciar_b = 1'b0; jogada_b = 1'b0; fim_timer_b = 1'b0; zero_b = 1'b0;
        for (int i = 0; i < 8; i++) rom[i] = 4'($urandom_range(0, 15));

        // Reset state and hold without iniciar
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_estado", 32'(db_estado), 32'h0);
        check("reset_outputs", 32'({zeraE, contaE, zeraL, contaL, zeraR, registraR, zera_timer,
                                    conta_timer, pronto, acertou, errou, timeout}), 32'h0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_hold", 32'(db_estado), 32'h0);

        // Round-0 trace, then reset while in comparacao
        n_last = 3'd2;
        @(posedge clock); #1 iniciar = 1'b1;
        @(posedge clock); #1 iniciar = 1'b0;
        @(negedge clock); check("trace_prep", 32'(db_estado), 32'h1);
        check("trace_prep_zera", 32'({zeraE, zeraL, zeraR, zera_timer}), 32'hF);
        @(negedge clock); check("trace_espera", 32'(db_estado), 32'h3);
        @(posedge clock); #1 play_val = rom[0]; jogada_feita = 1'b1;
        @(posedge clock); #1 jogada_feita = 1'b0;
        @(negedge clock); check("trace_registra", 32'(db_estado), 32'h4);
        @(negedge clock); check("trace_compara", 32'(db_estado), 32'h5);
        @(negedge clock); check("trace_prox_seq", 32'(db_estado), 32'h7);
        check("trace_contaL", 32'({contaL, contaE}), 32'h2);
        @(negedge clock); check("trace_nova_seq", 32'(db_estado), 32'h2);
        check("trace_zeraE", 32'({zeraE, zeraL}), 32'h2);
        @(negedge clock); check("trace_espera2", 32'(db_estado), 32'h3);
        @(posedge clock); #1 play_val = rom[0]; jogada_feita = 1'b1;
        @(posedge clock); #1 jogada_feita = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock); check("pre_reset_compara", 32'(db_estado), 32'h5);
        @(negedge clock);
        check("abort_estado", 32'(db_estado), 32'h0);
        check("abort_flags", 32'({pronto, acertou, errou}), 32'h0);
        @(posedge clock); #1 reset = 1'b0;

        // Directed games: success over 3 rounds, wrong second play, timeout on first play
        run_game(3, 0, 0, 0, ok);
        if (ok) run_game(3, 1, 1, 1, ok);
        if (ok) run_game(2, 2, 0, 0, ok);

        for (int g = 0; g < 25 && ok; g++) begin
            n = $urandom_range(1, 4);
            kind = $urandom_range(0, 2);
            fk = $urandom_range(0, n - 1);
            fj = $urandom_range(0, fk);
            run_game(n, kind, fk, fj, ok);
        end
        repeat (2) @(negedge clock);
        check("scoreboard_empty", sb_q.size(), 0);

        // Instance built without timeout: fim_timer is ignored while waiting
        @(posedge clock); #1 iniciar_b = 1'b1;
        @(posedge clock); #1 iniciar_b = 1'b0;
        @(negedge clock); check("nt_prep", 32'(db_estado_b), 32'h1);
        @(posedge clock); #1 fim_timer_b = 1'b1;
        repeat (5) @(negedge clock);
        check("nt_hold", 32'(db_estado_b), 32'h3);
        check("nt_no_timeout", 32'({pronto_b, timeout_b}), 32'h0);
        @(posedge clock); #1 jogada_b = 1'b1;
        @(posedge clock); #1 jogada_b = 1'b0; fim_timer_b = 1'b0;
        @(negedge clock); check("nt_registra", 32'(db_estado_b), 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
